down_port_arbiter: RTL and testbench

//  Round-robin, packet-atomic arbiter for the router's single downstream output (out_down).

---
 rtl/down_port_arbiter_if.sv | 24 ++
 rtl/down_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_down_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/down_port_arbiter_if.sv
// Request/pop handshake between the VC buffers, the NI and the downstream port arbiter.
// master = requester side (VC buffers / NI / credit return), slave = arbiter side.
interface down_port_arbiter_if;
  logic       vc0_valid;
  logic [1:0] vc0_type;
  logic       vc1_valid;
  logic [1:0] vc1_type;
  logic       ni_valid;
  logic [1:0] ni_type;
  logic       credit_in;
  logic       pop_vc0;
  logic       pop_vc1;
  logic       pop_ni;

  modport master (
    output vc0_valid, vc0_type, vc1_valid, vc1_type, ni_valid, ni_type, credit_in,
    input  pop_vc0, pop_vc1, pop_ni
  );

  modport slave (
    input  vc0_valid, vc0_type, vc1_valid, vc1_type, ni_valid, ni_type, credit_in,
    output pop_vc0, pop_vc1, pop_ni
  );
endinterface

// File: rtl/down_port_arbiter.sv
// Round-robin, packet-atomic, credit-aware arbiter for the downstream output (VC0, VC1, NI).
// Optional starvation watchdog enabled by defining ARB_WATCHDOG_EN.
module down_port_arbiter #(
  parameter  int CREDITS    = 4,
  parameter  int STARVE_LIM = 64,
  localparam int CW         = $clog2(CREDITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  down_port_arbiter_if.slave  req,
  output logic                sel_src,
  output logic                sel_vc,
  output logic                out_valid,
  output logic                busy,
  output logic [CW-1:0]       credit_cnt,
  output logic                starve_err
);

  localparam logic [1:0]    FT_HEAD  = 2'b01;
  localparam logic [1:0]    FT_TAIL  = 2'b10;
  localparam logic [1:0]    SRC_NI   = 2'd2;
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    owner_reg, owner_next;
  logic [1:0]    rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0] credit_cnt_reg, credit_next;
  logic          sel_src_reg, sel_vc_reg, out_valid_reg, busy_reg;

  // Index 3 is a permanently idle slot so 2-bit indices never fall off the end.
  logic [3:0]    req_valid;
  logic [1:0]    req_type [4];
  logic          win_found;
  logic [1:0]    win_idx, cand;
  logic          grant_valid;
  logic [1:0]    grant_idx;
  logic [2:0]    pop_vec;
  logic          has_credit;

  assign req_valid   = {1'b0, req.ni_valid, req.vc1_valid, req.vc0_valid};
  assign req_type[0] = req.vc0_type;
  assign req_type[1] = req.vc1_type;
  assign req_type[2] = req.ni_type;
  assign req_type[3] = 2'b00;
  assign has_credit  = (credit_cnt_reg != '0);

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    logic [2:0] t;
    t = (v >= 3'd3) ? v - 3'd3 : v;
    return t[1:0];
  endfunction

  // Scan from the far end so the requester closest to rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_reg;
    cand      = rr_ptr_reg;
    for (int k = 2; k >= 0; k--) begin
      cand = wrap3({1'b0, rr_ptr_reg} + 3'(k));
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      owner_reg  <= 2'd0;
      rr_ptr_reg <= 2'd0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_valid = 1'b0;
    grant_idx   = win_idx;
    case (state_reg)
      IDLE: begin
        if (win_found && has_credit) begin
          grant_valid = 1'b1;
          // Anything but a head is forwarded as a complete one-flit packet.
          if (req_type[win_idx] == FT_HEAD) begin
            state_next = LOCKED;
            owner_next = win_idx;
          end else begin
            rr_ptr_next = wrap3({1'b0, win_idx} + 3'd1);
          end
        end
      end
      LOCKED: begin
        grant_idx = owner_reg;
        if (req_valid[owner_reg] && has_credit) begin
          grant_valid = 1'b1;
          if (req_type[owner_reg] == FT_TAIL) begin
            state_next  = IDLE;
            rr_ptr_next = wrap3({1'b0, owner_reg} + 3'd1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop_vec = 3'b000;
    if (rst && grant_valid) begin
      pop_vec[grant_idx] = 1'b1;
    end
  end

  assign req.pop_vc0 = pop_vec[0];
  assign req.pop_vc1 = pop_vec[1];
  assign req.pop_ni  = pop_vec[2];

  always_comb begin
    credit_next = credit_cnt_reg;
    if (grant_valid && !req.credit_in) begin
      credit_next = credit_cnt_reg - 1'b1;
    end else if (!grant_valid && req.credit_in && credit_cnt_reg != CRED_MAX) begin
      credit_next = credit_cnt_reg + 1'b1;
    end
  end

  // Selects are registered to line up with the FIFO read data one cycle after the pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_cnt_reg <= CRED_MAX;
      sel_src_reg    <= 1'b0;
      sel_vc_reg     <= 1'b0;
      out_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      credit_cnt_reg <= credit_next;
      out_valid_reg  <= grant_valid;
      busy_reg       <= (state_reg == LOCKED) || (state_next == LOCKED);
      if (grant_valid) begin
        sel_src_reg <= (grant_idx != SRC_NI);
        sel_vc_reg  <= (grant_idx == 2'd1);
      end
    end
  end

  assign credit_cnt = credit_cnt_reg;
  assign sel_src    = sel_src_reg;
  assign sel_vc     = sel_vc_reg;
  assign out_valid  = out_valid_reg;
  assign busy       = busy_reg;

`ifdef ARB_WATCHDOG_EN
  localparam int            WW     = $clog2(STARVE_LIM + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(STARVE_LIM);

  logic [2:0] starve_hit;
  logic       starve_err_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_wd
    logic [WW-1:0] wait_reg, wait_next;

    always_comb begin
      wait_next = '0;
      if (req_valid[gi] && !pop_vec[gi]) begin
        wait_next = (wait_reg == WD_MAX) ? wait_reg : wait_reg + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wait_reg <= '0;
      end else begin
        wait_reg <= wait_next;
      end
    end

    assign starve_hit[gi] = (wait_next == WD_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_err_reg <= 1'b0;
    end else if (|starve_hit) begin
      starve_err_reg <= 1'b1;
    end
  end

  assign starve_err = starve_err_reg;
`else
  // Watchdog absent: flag tied low (STARVE_LIM referenced only to keep it live).
  assign starve_err = 1'b0 && (STARVE_LIM > 0);
`endif

endmodule

// File: tb/tb_down_port_arbiter.sv
// Self-checking bench for down_port_arbiter: directed scenarios plus a randomized run
// against a packet-level reference model. Honours ARB_WATCHDOG_EN if defined.
module tb_down_port_arbiter;
  localparam int CREDITS    = 4;
  localparam int STARVE_LIM = 8;
  localparam int CW         = $clog2(CREDITS + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  down_port_arbiter_if bus();
  logic          sel_src, sel_vc, out_valid, busy, starve_err;
  logic [CW-1:0] credit_cnt;

  down_port_arbiter #(.CREDITS(CREDITS), .STARVE_LIM(STARVE_LIM)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (bus),
    .sel_src    (sel_src),
    .sel_vc     (sel_vc),
    .out_valid  (out_valid),
    .busy       (busy),
    .credit_cnt (credit_cnt),
    .starve_err (starve_err)
  );

  int total = 0;
  int bad   = 0;

  bit         in_v [3];
  logic [1:0] in_t [3];
  bit         in_cr;

  // Reference model: packet lock, owner, rr pointer, credit count, per-source wait.
  bit m_locked;
  int m_owner, m_rr, m_cred;
  int m_wait [3];
  int exp_pop, obs_pop;
  bit e_ov, e_ss, e_sv, e_busy, e_starve;

  function automatic int dut_pop();
    int n = 0;
    int r = -1;
    if (bus.pop_vc0) begin n++; r = 0; end
    if (bus.pop_vc1) begin n++; r = 1; end
    if (bus.pop_ni)  begin n++; r = 2; end
    if (n > 1) r = 9;
    return r;
  endfunction

  function automatic bit exp_starve();
`ifdef ARB_WATCHDOG_EN
    return e_starve;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_in(input bit v0, input logic [1:0] t0, input bit v1, input logic [1:0] t1,
                        input bit vn, input logic [1:0] tn, input bit cr);
    in_v[0] = v0; in_t[0] = t0;
    in_v[1] = v1; in_t[1] = t1;
    in_v[2] = vn; in_t[2] = tn;
    in_cr   = cr;
    bus.vc0_valid = v0; bus.vc0_type = t0;
    bus.vc1_valid = v1; bus.vc1_type = t1;
    bus.ni_valid  = vn; bus.ni_type  = tn;
    bus.credit_in = cr;
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_owner = 0; m_rr = 0; m_cred = CREDITS;
    for (int i = 0; i < 3; i++) m_wait[i] = 0;
    e_ov = 1'b0; e_ss = 1'b0; e_sv = 1'b0; e_busy = 1'b0; e_starve = 1'b0;
  endtask

  task automatic model_predict();
    exp_pop = -1;
    if (rst && m_cred > 0) begin
      if (m_locked) begin
        if (in_v[m_owner]) exp_pop = m_owner;
      end else begin
        for (int k = 0; k < 3; k++)
          if (exp_pop < 0 && in_v[(m_rr + k) % 3]) exp_pop = (m_rr + k) % 3;
      end
    end
  endtask

  task automatic model_commit();
    bit was_locked;
    was_locked = m_locked;
    if (exp_pop >= 0) begin
      if (!m_locked) begin
        if (in_t[exp_pop] == 2'b01) begin
          m_locked = 1'b1;
          m_owner  = exp_pop;
        end else begin
          m_rr = (exp_pop + 1) % 3;
        end
      end else if (in_t[exp_pop] == 2'b10) begin
        m_locked = 1'b0;
        m_rr     = (exp_pop + 1) % 3;
      end
      m_cred--;
      e_ss = (exp_pop != 2);
      e_sv = (exp_pop == 1);
    end
    e_ov   = (exp_pop >= 0);
    e_busy = was_locked || m_locked;
    if (in_cr) m_cred++;
    if (m_cred > CREDITS) m_cred = CREDITS;
    for (int i = 0; i < 3; i++) begin
      if (in_v[i] && exp_pop != i) begin
        m_wait[i]++;
        if (m_wait[i] >= STARVE_LIM) e_starve = 1'b1;
      end else begin
        m_wait[i] = 0;
      end
    end
  endtask

  task automatic cycle();
    model_predict();
    @(negedge clk);
    obs_pop = dut_pop();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(0, 2'b00, 0, 2'b00, 0, 2'b00, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int p;
    do_reset();
    set_in(1, 2'b01, 0, 2'b00, 0, 2'b00, 0);
    cycle();
    total++; if (obs_pop !== 0) begin bad++; $display("FAIL rst_head_pop: got %0d want 0", obs_pop); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy_pre: got %b want 1", busy); end
    set_in(1, 2'b00, 1, 2'b11, 0, 2'b00, 0);
    #3;
    rst = 1'b0;
    #1;
    p = dut_pop();
    total++; if (p !== -1) begin bad++; $display("FAIL rst_pops: got %0d want -1", p); end
    total++; if ({out_valid, busy, sel_src, sel_vc, starve_err} !== 5'b0) begin
      bad++; $display("FAIL rst_outputs: got %b want 00000", {out_valid, busy, sel_src, sel_vc, starve_err}); end
    total++; if (credit_cnt !== CW'(CREDITS)) begin bad++; $display("FAIL rst_credit: got %0d want %0d", credit_cnt, CREDITS); end
    do_reset();
    set_in(1, 2'b11, 1, 2'b11, 1, 2'b11, 1);
    cycle();
    total++; if (obs_pop !== 0) begin bad++; $display("FAIL rst_rr_vc0: got %0d want 0", obs_pop); end
  endtask

  task automatic test_round_robin();
    int seq [4] = '{0, 1, 2, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 2'b11, 1, 2'b11, 1, 2'b11, 1);
      cycle();
      total++; if (obs_pop !== seq[i]) begin bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, obs_pop, seq[i]); end
      total++; if (out_valid !== 1'b1 || sel_src !== (seq[i] != 2) || sel_vc !== (seq[i] == 1)) begin
        bad++; $display("FAIL rr_sel[%0d]: got ov=%b src=%b vc=%b want src=%b vc=%b",
                        i, out_valid, sel_src, sel_vc, seq[i] != 2, seq[i] == 1); end
    end
    total++; if (credit_cnt !== CW'(CREDITS)) begin bad++; $display("FAIL rr_credit: got %0d want %0d", credit_cnt, CREDITS); end
  endtask

  task automatic test_atomicity();
    logic [1:0] ty [4]  = '{2'b01, 2'b00, 2'b10, 2'b00};
    bit         v0 [4]  = '{1, 1, 1, 0};
    int         pop [4] = '{0, 0, 0, 1};
    bit         bz [4]  = '{1, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(v0[i], ty[i], 1, 2'b11, 0, 2'b00, 1);
      cycle();
      total++; if (obs_pop !== pop[i]) begin bad++; $display("FAIL atom_pop[%0d]: got %0d want %0d", i, obs_pop, pop[i]); end
      total++; if (busy !== bz[i]) begin bad++; $display("FAIL atom_busy[%0d]: got %b want %b", i, busy, bz[i]); end
    end
  endtask

  task automatic test_credits();
    int pop [5]  = '{2, 2, 2, 2, -1};
    int cred [5] = '{3, 2, 1, 0, 0};
    int extra = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 2'b00, 0, 2'b00, 1, 2'b11, 0);
      cycle();
      total++; if (obs_pop !== pop[i]) begin bad++; $display("FAIL cred_pop[%0d]: got %0d want %0d", i, obs_pop, pop[i]); end
      total++; if (credit_cnt !== CW'(cred[i])) begin bad++; $display("FAIL cred_cnt[%0d]: got %0d want %0d", i, credit_cnt, cred[i]); end
    end
    set_in(0, 2'b00, 0, 2'b00, 1, 2'b11, 1);
    cycle();
    if (obs_pop == 2) extra++;
    for (int i = 0; i < 3; i++) begin
      set_in(0, 2'b00, 0, 2'b00, 1, 2'b11, 0);
      cycle();
      if (obs_pop == 2) extra++;
    end
    total++; if (extra !== 1) begin bad++; $display("FAIL cred_one_more: got %0d pops want 1", extra); end
    total++; if (credit_cnt !== CW'(0)) begin bad++; $display("FAIL cred_final: got %0d want 0", credit_cnt); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_in(0, 2'b00, 0, 2'b00, 1, 2'b11, 0);
    cycle();
    set_in(0, 2'b00, 0, 2'b00, 1, 2'b11, 1);
    cycle();
    total++; if (obs_pop !== 2) begin bad++; $display("FAIL simul_pop: got %0d want 2", obs_pop); end
    total++; if (credit_cnt !== CW'(3)) begin bad++; $display("FAIL simul_cnt: got %0d want 3", credit_cnt); end
    set_in(0, 2'b00, 0, 2'b00, 0, 2'b00, 1);
    cycle();
    set_in(0, 2'b00, 0, 2'b00, 0, 2'b00, 1);
    cycle();
    total++; if (credit_cnt !== CW'(CREDITS)) begin bad++; $display("FAIL simul_sat: got %0d want %0d", credit_cnt, CREDITS); end
  endtask

  task automatic test_watchdog();
    bit want_final;
`ifdef ARB_WATCHDOG_EN
    want_final = 1'b1;
`else
    want_final = 1'b0;
`endif
    do_reset();
    set_in(1, 2'b01, 0, 2'b00, 1, 2'b11, 1);
    cycle();
    for (int i = 0; i < 10; i++) begin
      set_in(0, 2'b00, 0, 2'b00, 1, 2'b11, 1);
      cycle();
      total++; if (obs_pop !== -1) begin bad++; $display("FAIL wd_hold[%0d]: got %0d want -1", i, obs_pop); end
      total++; if (starve_err !== exp_starve()) begin bad++; $display("FAIL wd_flag[%0d]: got %b want %b", i, starve_err, exp_starve()); end
    end
    total++; if (starve_err !== want_final) begin bad++; $display("FAIL wd_set: got %b want %b", starve_err, want_final); end
    set_in(1, 2'b10, 0, 2'b00, 1, 2'b11, 1);
    cycle();
    set_in(0, 2'b00, 0, 2'b00, 1, 2'b11, 1);
    cycle();
    total++; if (obs_pop !== 2) begin bad++; $display("FAIL wd_ni_pop: got %0d want 2", obs_pop); end
    total++; if (starve_err !== want_final) begin bad++; $display("FAIL wd_sticky: got %b want %b", starve_err, want_final); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 9) < 6, 2'($urandom), $urandom_range(0, 9) < 6, 2'($urandom),
             $urandom_range(0, 9) < 6, 2'($urandom), $urandom_range(0, 1) == 1);
      cycle();
      total++; if (obs_pop !== exp_pop) begin bad++; $display("FAIL rnd_pop[%0d]: got %0d want %0d", n, obs_pop, exp_pop); end
      total++; if (out_valid !== e_ov) begin bad++; $display("FAIL rnd_ov[%0d]: got %b want %b", n, out_valid, e_ov); end
      if (e_ov) begin
        total++; if ({sel_src, sel_vc} !== {e_ss, e_sv}) begin
          bad++; $display("FAIL rnd_sel[%0d]: got %b%b want %b%b", n, sel_src, sel_vc, e_ss, e_sv); end
      end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", n, busy, e_busy); end
      total++; if (credit_cnt !== CW'(m_cred)) begin bad++; $display("FAIL rnd_cred[%0d]: got %0d want %0d", n, credit_cnt, m_cred); end
      total++; if (starve_err !== exp_starve()) begin bad++; $display("FAIL rnd_starve[%0d]: got %b want %b", n, starve_err, exp_starve()); end
    end
  endtask

  initial begin
    set_in(0, 2'b00, 0, 2'b00, 0, 2'b00, 0);
    model_reset();
    test_reset();
    test_round_robin();
    test_atomicity();
    test_credits();
    test_simultaneous();
    test_watchdog();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
